// File: rtl/sram_arbiter_if.sv
// Cache-side bundle for sram_arbiter: ICache fill and DCache fill/store
// request/ready handshakes.
interface sram_arbiter_if #(
    parameter int LINE_WORDS = 4
);
    logic                       ic_req;
    logic [31:0]                ic_addr;
    logic                       ic_ready;
    logic [LINE_WORDS*32-1:0]   ic_line;
    logic                       dc_req;
    logic                       dc_we;
    logic [31:0]                dc_addr;
    logic [31:0]                dc_wdata;
    logic                       dc_ready;
    logic [LINE_WORDS*32-1:0]   dc_line;

    modport master (
        output ic_req, ic_addr,
        output dc_req, dc_we, dc_addr, dc_wdata,
        input  ic_ready, ic_line,
        input  dc_ready, dc_line
    );

    modport slave (
        input  ic_req, ic_addr,
        input  dc_req, dc_we, dc_addr, dc_wdata,
        output ic_ready, ic_line,
        output dc_ready, dc_line
    );
endinterface

// File: rtl/sram_arbiter.sv
// Arbitrates ICache/DCache access to the base/ext SRAM banks and sequences
// the multi-cycle line-read and single-word-write timing.
module sram_arbiter #(
    parameter int LINE_WORDS  = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    sram_arbiter_if.slave bus,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n,
    output logic [19:0] base_ram_addr,
    inout  wire  [31:0] base_ram_data,
    output logic        ext_ram_ce_n,
    output logic        ext_ram_oe_n,
    output logic        ext_ram_we_n,
    output logic [19:0] ext_ram_addr,
    input  logic [31:0] ext_ram_data_in,
    output logic [31:0] ext_ram_data_out
);

    localparam int LW_BITS = $clog2(LINE_WORDS);
    localparam int WW      = $clog2(WAIT_CYCLES + 1);
    localparam int LINE_W  = LINE_WORDS * 32;
    localparam logic [WW-1:0]      WAIT_LAST = WW'(WAIT_CYCLES - 1);
    localparam logic [LW_BITS-1:0] WORD_LAST = LW_BITS'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic                gnt_dc_q, gnt_dc_d;
    logic [20:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [LW_BITS-1:0]  word_q, word_d;
    logic [WW-1:0]       wait_q, wait_d;
    logic [LINE_W-1:0]   ic_line_q, ic_line_d;
    logic [LINE_W-1:0]   dc_line_q, dc_line_d;

    logic                bank_ext;
    logic                rd_phase;
    logic                wr_phase;
    logic [19:0]         ram_addr;
    logic [31:0]         rd_data;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{bus.ic_addr[31:23], bus.ic_addr[1:0],
                                bus.dc_addr[31:23], bus.dc_addr[1:0]};

    // addr_q holds byte address bits [22:2]: bit 20 is the bank select
    assign bank_ext = addr_q[20];
    assign rd_phase = (state_q == S_RD);
    assign wr_phase = (state_q == S_WR_SETUP) || (state_q == S_WR_PULSE) ||
                      (state_q == S_WR_HOLD);
    assign rd_data  = bank_ext ? ext_ram_data_in : base_ram_data;

    always_comb begin
        state_d   = state_q;
        gnt_dc_d  = gnt_dc_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        word_d    = word_q;
        wait_d    = wait_q;
        ic_line_d = ic_line_q;
        dc_line_d = dc_line_q;
        unique case (state_q)
            S_IDLE: begin
                word_d = '0;
                wait_d = '0;
                if (bus.dc_req) begin
                    gnt_dc_d = 1'b1;
                    addr_d   = bus.dc_addr[22:2];
                    wdata_d  = bus.dc_wdata;
                    state_d  = bus.dc_we ? S_WR_SETUP : S_RD;
                end else if (bus.ic_req) begin
                    gnt_dc_d = 1'b0;
                    addr_d   = bus.ic_addr[22:2];
                    state_d  = S_RD;
                end
            end
            S_RD: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d = '0;
                    word_d = word_q + LW_BITS'(1);
                    if (gnt_dc_q)
                        dc_line_d[word_q*32 +: 32] = rd_data;
                    else
                        ic_line_d[word_q*32 +: 32] = rd_data;
                    if (word_q == WORD_LAST)
                        state_d = S_DONE;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_WR_SETUP: state_d = S_WR_PULSE;
            S_WR_PULSE: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = S_WR_HOLD;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_WR_HOLD: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            gnt_dc_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            word_q    <= '0;
            wait_q    <= '0;
            ic_line_q <= '0;
            dc_line_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_dc_q  <= gnt_dc_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            word_q    <= word_d;
            wait_q    <= wait_d;
            ic_line_q <= ic_line_d;
            dc_line_q <= dc_line_d;
        end
    end

    // Reads walk the aligned line; writes use the captured word address
    always_comb begin
        ram_addr = addr_q[19:0];
        if (rd_phase)
            ram_addr = {addr_q[19:LW_BITS], word_q};
    end

    assign base_ram_ce_n = !((rd_phase || wr_phase) && !bank_ext);
    assign base_ram_oe_n = !(rd_phase && !bank_ext);
    assign base_ram_we_n = !((state_q == S_WR_PULSE) && !bank_ext);
    assign base_ram_addr = ram_addr;
    assign base_ram_data = (wr_phase && !bank_ext) ? wdata_q : 32'hzzzz_zzzz;

    assign ext_ram_ce_n     = !((rd_phase || wr_phase) && bank_ext);
    assign ext_ram_oe_n     = !(rd_phase && bank_ext);
    assign ext_ram_we_n     = !((state_q == S_WR_PULSE) && bank_ext);
    assign ext_ram_addr     = ram_addr;
    assign ext_ram_data_out = wdata_q;

    assign bus.ic_ready = (state_q == S_DONE) && !gnt_dc_q;
    assign bus.dc_ready = (state_q == S_DONE) && gnt_dc_q;
    assign bus.ic_line  = ic_line_q;
    assign bus.dc_line  = dc_line_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one default instance and one with
// WAIT_CYCLES = 2, each against a small behavioural SRAM model.
module tb_sram_arbiter;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    sram_arbiter_if #(.LINE_WORDS(4)) bus1 ();
    sram_arbiter_if #(.LINE_WORDS(4)) bus2 ();

    logic        b_ce_n, b_oe_n, b_we_n, e_ce_n, e_oe_n, e_we_n;
    logic [19:0] b_addr, e_addr;
    wire  [31:0] b_data;
    logic [31:0] e_din, e_dout;

    logic        b2_ce_n, b2_oe_n, b2_we_n, e2_ce_n, e2_oe_n, e2_we_n;
    logic [19:0] b2_addr, e2_addr;
    wire  [31:0] b2_data;
    logic [31:0] e2_din, e2_dout;

    logic [31:0] base_mem [256];
    logic [31:0] wr1 [256];
    logic [31:0] rom2 [256];
    logic [31:0] wr2 [256];

    sram_arbiter u_dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus1.slave),
        .base_ram_ce_n    (b_ce_n),
        .base_ram_oe_n    (b_oe_n),
        .base_ram_we_n    (b_we_n),
        .base_ram_addr    (b_addr),
        .base_ram_data    (b_data),
        .ext_ram_ce_n     (e_ce_n),
        .ext_ram_oe_n     (e_oe_n),
        .ext_ram_we_n     (e_we_n),
        .ext_ram_addr     (e_addr),
        .ext_ram_data_in  (e_din),
        .ext_ram_data_out (e_dout)
    );

    sram_arbiter #(.LINE_WORDS(4), .WAIT_CYCLES(2)) u_dut2 (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus2.slave),
        .base_ram_ce_n    (b2_ce_n),
        .base_ram_oe_n    (b2_oe_n),
        .base_ram_we_n    (b2_we_n),
        .base_ram_addr    (b2_addr),
        .base_ram_data    (b2_data),
        .ext_ram_ce_n     (e2_ce_n),
        .ext_ram_oe_n     (e2_oe_n),
        .ext_ram_we_n     (e2_we_n),
        .ext_ram_addr     (e2_addr),
        .ext_ram_data_in  (e2_din),
        .ext_ram_data_out (e2_dout)
    );

    assign b_data = (!b_ce_n && !b_oe_n) ? base_mem[b_addr[7:0]] : 32'hzzzz_zzzz;
    assign e_din  = 32'h0;
    assign e2_din = rom2[e2_addr[7:0]];

    always @(posedge clk) begin
        if (!e_ce_n && !e_we_n)
            wr1[e_addr[7:0]] <= e_dout;
        if (!e2_ce_n && !e2_we_n)
            wr2[e2_addr[7:0]] <= e2_dout;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] strb1();
        return {b_ce_n, b_oe_n, b_we_n, e_ce_n, e_oe_n, e_we_n};
    endfunction

    function automatic logic [5:0] strb2();
        return {b2_ce_n, b2_oe_n, b2_we_n, e2_ce_n, e2_oe_n, e2_we_n};
    endfunction

    function automatic logic [1:0] rdy1();
        return {bus1.ic_ready, bus1.dc_ready};
    endfunction

    localparam logic [127:0] LINE_A = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    localparam logic [127:0] LINE_B = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    localparam logic [127:0] LINE_C = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    localparam logic [127:0] LINE_D = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < 256; i++) begin
            base_mem[i] = 32'h0;
            rom2[i]     = 32'h0;
        end
        for (int i = 0; i < 4; i++) begin
            base_mem[4 + i]    = 32'hA0 + i;
            base_mem[8'h40 + i] = 32'hB0 + i;
            base_mem[i]        = 32'hC0 + i;
            rom2[8 + i]        = 32'hD0 + i;
        end
        rst            = 1'b0;
        bus1.ic_req    = 1'b1;
        bus1.ic_addr   = 32'h8000_0014;
        bus1.dc_req    = 1'b1;
        bus1.dc_we     = 1'b0;
        bus1.dc_addr   = 32'h8000_0100;
        bus1.dc_wdata  = 32'h0;
        bus2.ic_req    = 1'b0;
        bus2.ic_addr   = 32'h0;
        bus2.dc_req    = 1'b0;
        bus2.dc_we     = 1'b0;
        bus2.dc_addr   = 32'h0;
        bus2.dc_wdata  = 32'h0;

        // reset held with both requests up
        repeat (3) begin
            tick();
            check("rst_strb", strb1(), 6'h3f);
            check("rst_rdy", rdy1(), 2'b00);
        end
        check("rst_ic_line", bus1.ic_line, 128'h0);
        check("rst_addr", {b_addr, e_addr}, 40'h0);
        check("rst_dout", e_dout, 32'h0);
        bus1.ic_req = 1'b0;
        bus1.dc_req = 1'b0;
        rst = 1'b1;
        tick();
        check("post_rst_idle", strb1(), 6'h3f);

        // ICache fill from base, words 4..7
        bus1.ic_req  = 1'b1;
        bus1.ic_addr = 32'h8000_0014;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("if_addr", b_addr, 20'(4 + k));
            check("if_strb", strb1(), 6'b001111);
        end
        tick();
        check("if_rdy", rdy1(), 2'b10);
        check("if_line", bus1.ic_line, LINE_A);
        bus1.ic_req = 1'b0;
        tick();
        check("if_idle_rdy", rdy1(), 2'b00);

        // simultaneous requests: DCache first
        bus1.ic_req  = 1'b1;
        bus1.ic_addr = 32'h8000_0004;
        bus1.dc_req  = 1'b1;
        bus1.dc_we   = 1'b0;
        bus1.dc_addr = 32'h8000_0100;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("sim_dc_addr", b_addr, 20'(8'h40 + k));
        end
        tick();
        check("sim_dc_rdy", rdy1(), 2'b01);
        check("sim_dc_line", bus1.dc_line, LINE_B);
        check("sim_ic_hold", bus1.ic_line, LINE_A);
        bus1.dc_req = 1'b0;
        tick();
        check("sim_gap", strb1(), 6'h3f);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("sim_ic_addr", b_addr, 20'(k));
            check("sim_ic_strb", strb1(), 6'b001111);
        end
        tick();
        check("sim_ic_rdy", rdy1(), 2'b10);
        check("sim_ic_line", bus1.ic_line, LINE_C);
        bus1.ic_req = 1'b0;
        tick();

        // reset during the second read word
        bus1.ic_req  = 1'b1;
        bus1.ic_addr = 32'h8000_0014;
        tick();
        tick();
        check("mr_addr", b_addr, 20'd5);
        rst = 1'b0;
        tick();
        check("mr_strb", strb1(), 6'h3f);
        check("mr_rdy", rdy1(), 2'b00);
        check("mr_line", bus1.ic_line, 128'h0);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mr_re_addr", b_addr, 20'(4 + k));
        end
        tick();
        check("mr_re_rdy", rdy1(), 2'b10);
        check("mr_re_line", bus1.ic_line, LINE_A);
        bus1.ic_req = 1'b0;
        tick();

        // DCache stores held back-to-back while ICache waits
        bus1.ic_req   = 1'b1;
        bus1.ic_addr  = 32'h8000_0014;
        bus1.dc_req   = 1'b1;
        bus1.dc_we    = 1'b1;
        bus1.dc_addr  = 32'h8040_0010;
        bus1.dc_wdata = 32'h1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_setup", strb1(), 6'b111011);
            check("st_addr", e_addr, 20'(4 + i));
            tick();
            check("st_pulse", strb1(), 6'b111010);
            tick();
            check("st_hold", strb1(), 6'b111011);
            tick();
            check("st_rdy", rdy1(), 2'b01);
            if (i == 2) begin
                bus1.dc_req = 1'b0;
                bus1.dc_we  = 1'b0;
            end else begin
                bus1.dc_addr  = 32'h8040_0014 + 32'(4 * i);
                bus1.dc_wdata = 32'h1001 + 32'(i);
            end
            tick();
            check("st_idle", strb1(), 6'h3f);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            check("st_ic_addr", b_addr, 20'(4 + k));
            check("st_ic_strb", strb1(), 6'b001111);
        end
        tick();
        check("st_ic_rdy", rdy1(), 2'b10);
        bus1.ic_req = 1'b0;
        tick();
        for (int i = 0; i < 3; i++)
            check("st_mem", wr1[4 + i], 32'h1000 + 32'(i));
        check("st_dc_line", bus1.dc_line, 128'h0);

        // WAIT_CYCLES = 2: ext store
        bus2.dc_req   = 1'b1;
        bus2.dc_we    = 1'b1;
        bus2.dc_addr  = 32'h8040_0008;
        bus2.dc_wdata = 32'hDEAD_BEEF;
        tick();
        check("w2_setup", strb2(), 6'b111011);
        check("w2_addr", e2_addr, 20'd2);
        tick();
        check("w2_pulse0", strb2(), 6'b111010);
        tick();
        check("w2_pulse1", strb2(), 6'b111010);
        tick();
        check("w2_hold", strb2(), 6'b111011);
        check("w2_no_rdy", bus2.dc_ready, 1'b0);
        tick();
        check("w2_rdy", {bus2.ic_ready, bus2.dc_ready}, 2'b01);
        check("w2_done_strb", strb2(), 6'h3f);
        bus2.dc_req = 1'b0;
        bus2.dc_we  = 1'b0;
        tick();
        check("w2_mem", wr2[2], 32'hDEAD_BEEF);

        // WAIT_CYCLES = 2: ext line read, two cycles per word
        bus2.dc_req  = 1'b1;
        bus2.dc_addr = 32'h8040_0020;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("r2_addr", e2_addr, 20'(8 + k / 2));
            check("r2_strb", strb2(), 6'b111001);
        end
        tick();
        check("r2_rdy", {bus2.ic_ready, bus2.dc_ready}, 2'b01);
        check("r2_line", bus2.dc_line, LINE_D);
        bus2.dc_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
